// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU adapter family.
//   - cfu_fn_e      : function select codes (low two bits of the function ID)
//   - CFU_ERR_*     : error codes reported in resp_error_id
//   - cfu_resp_t    : response entry {id, data, ok, error_id} at default widths
//   - cfu_ptr_w()   : pointer width helper that stays >= 1 for single-entry FIFOs
package cfu_pkg;

    typedef enum logic [1:0] {
        CFU_FN_MUL = 2'd0,
        CFU_FN_ADD = 2'd1,
        CFU_FN_SUB = 2'd2,
        CFU_FN_XOR = 2'd3
    } cfu_fn_e;

    localparam int CFU_FN_MAX   = 3;

    localparam int CFU_ERR_NONE = 0;
    localparam int CFU_ERR_IID  = 1;
    localparam int CFU_ERR_FUNC = 2;

    localparam int CFU_DEF_ID_W   = 6;
    localparam int CFU_DEF_DATA_W = 32;
    localparam int CFU_DEF_ERR_W  = 32;

    // Response entry at the default interface widths; modules with other
    // widths declare a matching local struct of the same field order.
    typedef struct packed {
        logic [CFU_DEF_ID_W-1:0]   id;
        logic [CFU_DEF_DATA_W-1:0] data;
        logic                      ok;
        logic [CFU_DEF_ERR_W-1:0]  error_id;
    } cfu_resp_t;

    function automatic int cfu_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cfu_resp_fifo.sv
// In-order response FIFO. Synchronous push/pop, asynchronous active-low reset
// of the pointers and count (stored payloads are not reset; head is only
// meaningful while empty_o is 0). No fall-through: an entry pushed at an edge
// becomes visible at head_o after that edge. Credits are managed by the caller,
// so no full flag is provided.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   push_i       write push_data_i at the tail
//   push_data_i  entry to enqueue
//   pop_i        drop the head entry (ignored when empty)
//   empty_o      no entries stored
//   head_o       oldest stored entry
module cfu_resp_fifo
    import cfu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW    = cfu_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_eff;

    // Explicit wrap keeps a depth-1 FIFO's pointer pinned at zero.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop_eff = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_eff) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_eff) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_i && pop_eff) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cfu_pipelined_credit_adapter.sv
// Credit-based CFU adapter: a fixed-latency function pipeline feeding an
// in-order response FIFO. A request is admitted only when a FIFO slot is
// reserved for it, so the pipeline never stalls and resp_ready never reaches
// req_ready combinationally.
// Ports:
//   clock, reset (async, active low), clock_en (0 = freeze everything)
//   req_ready/req_valid/req_interface_id/req_function_id/req_id/req_data
//       request channel; req_data = {operand[1], operand[0]}
//   resp_ready/resp_valid/resp_id/resp_data/resp_ok/resp_error_id
//       response channel, delivered in acceptance order
// Functions: 0 MUL (low), 1 ADD, 2 SUB ([0]-[1]), 3 XOR, all modulo 2^RESP_W.
// Errors: wrong interface ID -> code 1; function ID > 3 -> code 2; data 0.
module cfu_pipelined_credit_adapter
    import cfu_pkg::*;
#(
    parameter int CFU_IID            = 0,
    parameter int CFU_INTERFACE_ID_W = 16,
    parameter int CFU_FUNCTION_ID_W  = 16,
    parameter int CFU_REQ_RESP_ID_W  = 6,
    parameter int CFU_REQ_DATA_W     = 32,
    parameter int CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
    parameter int CFU_ERROR_ID_W     = CFU_RESP_DATA_W,
    parameter int LATENCY            = 3,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clock_en,
    output logic                          req_ready,
    input  logic                          req_valid,
    input  logic [CFU_INTERFACE_ID_W-1:0] req_interface_id,
    input  logic [CFU_FUNCTION_ID_W-1:0]  req_function_id,
    input  logic [CFU_REQ_RESP_ID_W-1:0]  req_id,
    input  logic [2*CFU_REQ_DATA_W-1:0]   req_data,
    input  logic                          resp_ready,
    output logic                          resp_valid,
    output logic [CFU_REQ_RESP_ID_W-1:0]  resp_id,
    output logic [CFU_RESP_DATA_W-1:0]    resp_data,
    output logic                          resp_ok,
    output logic [CFU_ERROR_ID_W-1:0]     resp_error_id
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CW    = (CFU_REQ_DATA_W > CFU_RESP_DATA_W) ? CFU_REQ_DATA_W : CFU_RESP_DATA_W;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [CFU_REQ_RESP_ID_W-1:0] id;
        logic [CFU_RESP_DATA_W-1:0]   data;
        logic                         ok;
        logic [CFU_ERROR_ID_W-1:0]    error_id;
    } resp_t;

    localparam int ENTRY_W = $bits(resp_t);

    // ---------------- parameter legality ----------------
    if (LATENCY < 1) begin : g_chk_latency
        $error("LATENCY must be at least 1");
    end
    if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two and at least 1");
    end
    if (CFU_FUNCTION_ID_W < 2) begin : g_chk_fn_w
        $error("CFU_FUNCTION_ID_W must be at least 2");
    end

    // ---------------- credits ----------------
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             accept;
    logic             deliver;
    logic             fifo_empty;

    // Gating with reset keeps req_ready low while reset is held; occ_q alone
    // is already 0 then, but clock_en may be high.
    assign req_ready  = reset & clock_en & (occ_q < DEPTH_OCC);
    assign accept     = req_valid & req_ready;
    assign resp_valid = clock_en & ~fifo_empty;
    assign deliver    = resp_valid & resp_ready;

    // A slot freed by this cycle's delivery only shows up as a credit next
    // cycle, because req_ready is derived from the registered count.
    always_comb begin
        occ_d = occ_q;
        if (accept && !deliver) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && deliver) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // ---------------- function evaluation ----------------
    logic [CW-1:0] op_a, op_b, calc;
    resp_t         new_entry;

    assign op_a = CW'(req_data[CFU_REQ_DATA_W-1:0]);
    assign op_b = CW'(req_data[2*CFU_REQ_DATA_W-1:CFU_REQ_DATA_W]);

    always_comb begin
        calc = '0;
        case (cfu_fn_e'(req_function_id[1:0]))
            CFU_FN_MUL: calc = op_a * op_b;
            CFU_FN_ADD: calc = op_a + op_b;
            CFU_FN_SUB: calc = op_a - op_b;
            CFU_FN_XOR: calc = op_a ^ op_b;
        endcase
    end

    always_comb begin
        new_entry.id       = req_id;
        new_entry.data     = calc[CFU_RESP_DATA_W-1:0];
        new_entry.ok       = 1'b1;
        new_entry.error_id = CFU_ERROR_ID_W'(CFU_ERR_NONE);
        if (req_interface_id != CFU_INTERFACE_ID_W'(CFU_IID)) begin
            new_entry.data     = '0;
            new_entry.ok       = 1'b0;
            new_entry.error_id = CFU_ERROR_ID_W'(CFU_ERR_IID);
        end else if (req_function_id > CFU_FUNCTION_ID_W'(CFU_FN_MAX)) begin
            new_entry.data     = '0;
            new_entry.ok       = 1'b0;
            new_entry.error_id = CFU_ERROR_ID_W'(CFU_ERR_FUNC);
        end
    end

    // ---------------- pipeline ----------------
    // LATENCY-1 register stages sit in front of the FIFO; together with the
    // FIFO write edge this gives resp_valid exactly LATENCY cycles after accept.
    logic  push_valid;
    resp_t push_entry;

    if (LATENCY == 1) begin : g_nopipe
        assign push_valid = accept;
        assign push_entry = new_entry;
    end else begin : g_pipe
        localparam int NSTG = LATENCY - 1;

        logic  vld_q [NSTG];
        logic  vld_in [NSTG];
        resp_t ent_q [NSTG];
        resp_t ent_in [NSTG];

        for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage_in
            if (gi == 0) begin : g_head
                assign vld_in[gi] = accept;
                assign ent_in[gi] = new_entry;
            end else begin : g_shift
                assign vld_in[gi] = vld_q[gi-1];
                assign ent_in[gi] = ent_q[gi-1];
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < NSTG; i++) begin
                    vld_q[i] <= 1'b0;
                end
            end else if (clock_en) begin
                for (int i = 0; i < NSTG; i++) begin
                    vld_q[i] <= vld_in[i];
                end
            end
        end

        // Payloads need no reset: they are qualified by vld_q.
        always_ff @(posedge clock) begin
            if (clock_en) begin
                for (int i = 0; i < NSTG; i++) begin
                    ent_q[i] <= ent_in[i];
                end
            end
        end

        assign push_valid = clock_en & vld_q[NSTG-1];
        assign push_entry = ent_q[NSTG-1];
    end

    // ---------------- response FIFO ----------------
    logic [ENTRY_W-1:0] fifo_head;
    resp_t              head_entry;

    cfu_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_resp_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .push_i      (push_valid),
        .push_data_i (push_entry),
        .pop_i       (deliver),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign head_entry = resp_t'(fifo_head);

    // Head fields are shown whenever the FIFO holds data (so they hold through
    // clock_en=0); an empty FIFO presents the idle/reset response values.
    always_comb begin
        resp_id       = '0;
        resp_data     = '0;
        resp_ok       = 1'b1;
        resp_error_id = '0;
        if (!fifo_empty) begin
            resp_id       = head_entry.id;
            resp_data     = head_entry.data;
            resp_ok       = head_entry.ok;
            resp_error_id = head_entry.error_id;
        end
    end

endmodule

// File: tb/tb_cfu_pipelined_credit_adapter.sv
module tb_cfu_pipelined_credit_adapter;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        clock_en;
    logic        req_ready;
    logic        req_valid;
    logic [15:0] req_interface_id;
    logic [15:0] req_function_id;
    logic [5:0]  req_id;
    logic [63:0] req_data;
    logic        resp_ready;
    logic        resp_valid;
    logic [5:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_ok;
    logic [31:0] resp_error_id;

    cfu_pipelined_credit_adapter #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .clock_en         (clock_en),
        .req_ready        (req_ready),
        .req_valid        (req_valid),
        .req_interface_id (req_interface_id),
        .req_function_id  (req_function_id),
        .req_id           (req_id),
        .req_data         (req_data),
        .resp_ready       (resp_ready),
        .resp_valid       (resp_valid),
        .resp_id          (resp_id),
        .resp_data        (resp_data),
        .resp_ok          (resp_ok),
        .resp_error_id    (resp_error_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected response plus the enabled-cycle index at which it becomes visible.
    typedef struct {
        logic [5:0]  id;
        logic [31:0] data;
        logic        ok;
        logic [31:0] err;
        int          vis;
    } exp_t;

    exp_t q[$];
    int   en_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference behaviour straight from the function/error rules.
    function automatic exp_t ref_model(input logic [15:0] iid, input logic [15:0] fn,
                                       input logic [5:0] id, input logic [31:0] a,
                                       input logic [31:0] b);
        exp_t        r;
        logic [63:0] p;
        r.id   = id;
        r.ok   = 1'b1;
        r.err  = 32'd0;
        r.data = 32'd0;
        r.vis  = 0;
        if (iid != 16'd0) begin
            r.ok  = 1'b0;
            r.err = 32'd1;
        end else if (fn > 16'd3) begin
            r.ok  = 1'b0;
            r.err = 32'd2;
        end else begin
            case (fn)
                16'd0: begin
                    p      = {32'd0, a} * {32'd0, b};
                    r.data = p[31:0];
                end
                16'd1: r.data = a + b;
                16'd2: r.data = a - b;
                default: r.data = a ^ b;
            endcase
        end
        return r;
    endfunction

    task automatic set_req(input logic [15:0] iid, input logic [15:0] fn, input logic [5:0] id,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid        = 1'b1;
        req_interface_id = iid;
        req_function_id  = fn;
        req_id           = id;
        req_data         = {b, a};
    endtask

    // One clock cycle: check outputs on the falling edge, then update the
    // model with the handshakes that happen at the rising edge.
    task automatic step(output bit acc);
        bit   exp_ready;
        bit   exp_valid;
        bit   head_vis;
        bit   del;
        exp_t e;
        @(negedge clock);
        cyc++;
        head_vis  = (q.size() > 0) && (q[0].vis <= en_cnt);
        exp_ready = reset && clock_en && (q.size() < DEPTH);
        exp_valid = clock_en && head_vis;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("resp_valid", 64'(resp_valid), 64'(exp_valid));
        if (head_vis) begin
            check("resp_id", 64'(resp_id), 64'(q[0].id));
            check("resp_data", 64'(resp_data), 64'(q[0].data));
            check("resp_ok", 64'(resp_ok), 64'(q[0].ok));
            check("resp_error_id", 64'(resp_error_id), 64'(q[0].err));
        end
        acc = req_valid && exp_ready;
        del = exp_valid && resp_ready;
        @(posedge clock);
        if (del) begin
            $display("[cyc %0d] deliver id=%0d data=%08h ok=%0d err=%0d",
                     cyc, q[0].id, q[0].data, q[0].ok, q[0].err);
            void'(q.pop_front());
        end
        if (acc) begin
            e     = ref_model(req_interface_id, req_function_id, req_id,
                              req_data[31:0], req_data[63:32]);
            e.vis = en_cnt + LAT;
            q.push_back(e);
            $display("[cyc %0d] accept  id=%0d iid=%0d fn=%0d a=%08h b=%08h",
                     cyc, req_id, req_interface_id, req_function_id,
                     req_data[31:0], req_data[63:32]);
        end
        if (clock_en && reset) en_cnt++;
        #1;
    endtask

    initial begin
        bit          acc;
        int          n;
        logic [31:0] ra, rb;

        reset            = 1'b0;
        clock_en         = 1'b1;
        req_valid        = 1'b0;
        req_interface_id = '0;
        req_function_id  = '0;
        req_id           = '0;
        req_data         = '0;
        resp_ready       = 1'b1;

        // Reset values.
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_ok", 64'(resp_ok), 64'd1);
        check("rst_resp_error_id", 64'(resp_error_id), 64'd0);
        repeat (3) step(acc);
        reset = 1'b1;

        // Single request: 7 x 6 with id 5.
        set_req(16'd0, 16'd0, 6'd5, 32'd7, 32'd6);
        step(acc);
        req_valid = 1'b0;
        repeat (5) step(acc);

        // Streaming: 16 back-to-back ADDs.
        for (int i = 0; i < 16; i++) begin
            set_req(16'd0, 16'd1, 6'(i), $urandom, $urandom);
            step(acc);
        end
        req_valid = 1'b0;
        repeat (6) step(acc);

        // Back-pressure: consumer stalled, then released.
        resp_ready = 1'b0;
        n = 0;
        set_req(16'd0, 16'($urandom_range(0, 3)), 6'(16 + n), $urandom, $urandom);
        for (int k = 0; k < 8; k++) begin
            step(acc);
            if (acc) begin
                n++;
                set_req(16'd0, 16'($urandom_range(0, 3)), 6'(16 + n), $urandom, $urandom);
            end
        end
        resp_ready = 1'b1;
        for (int k = 0; k < 16 && n < 6; k++) begin
            step(acc);
            if (acc) begin
                n++;
                set_req(16'd0, 16'($urandom_range(0, 3)), 6'(16 + n), $urandom, $urandom);
            end
        end
        req_valid = 1'b0;
        repeat (8) step(acc);

        // Errors and arithmetic wrap.
        set_req(16'd3, 16'd0, 6'd30, 32'd1, 32'd2);
        step(acc);
        set_req(16'd0, 16'd9, 6'd31, 32'd5, 32'd5);
        step(acc);
        set_req(16'd0, 16'd2, 6'd32, 32'd0, 32'd1);
        step(acc);
        set_req(16'd0, 16'd0, 6'd33, 32'hFFFF_FFFF, 32'd2);
        step(acc);
        req_valid = 1'b0;
        repeat (6) step(acc);

        // Random mix with a 5-cycle clock_en gap in the middle.
        for (int k = 0; k < 60; k++) begin
            ra = $urandom;
            rb = $urandom;
            set_req(($urandom_range(0, 7) == 0) ? 16'd2 : 16'd0,
                    16'($urandom_range(0, 5)), 6'($urandom_range(0, 63)), ra, rb);
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            clock_en   = !(k >= 20 && k < 25);
            step(acc);
        end
        clock_en   = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (10) step(acc);

        // Reset with responses both queued and in flight.
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(16'd0, 16'd1, 6'(40 + i), $urandom, $urandom);
            step(acc);
        end
        req_valid = 1'b0;
        step(acc);
        reset = 1'b0;
        #1;
        check("async_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("async_rst_req_ready", 64'(req_ready), 64'd0);
        q.delete();
        repeat (2) step(acc);
        reset      = 1'b1;
        resp_ready = 1'b1;
        set_req(16'd0, 16'd3, 6'd50, 32'h1234_5678, 32'h0F0F_0F0F);
        step(acc);
        req_valid = 1'b0;
        repeat (8) step(acc);
        check("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
